// File: rtl/demux_stream_router.sv
// demux_stream_router: routes a valid/ready input stream to one of NUM_CH
// output channels, each backed by a one-entry output register.
// Routing target comes from in_sel (addressed mode) or an internal
// round-robin pointer (scan mode). Out-of-range addressed beats are
// swallowed and counted in a saturating drop counter.
// Optional feature macro: DEMUX_BCAST_EN (broadcast of one beat to all
// channels when bcast is high). Without it, bcast is ignored.
module demux_stream_router #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     bcast,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]         scan_ptr,
  output logic [CNT_W-1:0]         drop_cnt
);

  // One bit wider than the select so NUM_CH == 2**SEL_W is representable.
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  target;
  logic              in_range;
  logic [NUM_CH-1:0] room;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] load;
  logic              bcast_sel;
  logic              accept;
  logic              ptr_adv;
  logic              drop_inc;

`ifndef DEMUX_BCAST_EN
  logic unused_bcast;
  assign unused_bcast = bcast;
`endif

  // Target decode, ready generation and per-channel load strobes.
  always_comb begin
    room      = ~out_valid | out_ready;
    target    = mode ? scan_ptr : in_sel;
    in_range  = {1'b0, target} < CH_LIM;
    hit       = '0;
    bcast_sel = 1'b0;
`ifdef DEMUX_BCAST_EN
    bcast_sel = bcast;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (target == SEL_W'(i)) hit[i] = 1'b1;
    end
    // Ready depends only on target state, never on in_valid.
    if (bcast_sel)      in_ready = &room;
    else if (!in_range) in_ready = 1'b1;
    else                in_ready = |(hit & room);
    accept   = in_valid && in_ready;
    load     = '0;
    if (accept) load = bcast_sel ? '1 : hit;
    ptr_adv  = accept && mode && !bcast_sel;
    drop_inc = accept && !mode && !in_range && !bcast_sel;
  end

  // Per-channel output registers: load wins over drain so a coincident
  // drain and load keeps the channel full with the new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          out_valid[i]                   <= 1'b1;
          out_data[i*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]                   <= 1'b0;
        end
      end
    end
  end

  // Round-robin scan pointer, advancing only on scan-mode accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
    end else if (ptr_adv) begin
      scan_ptr <= (scan_ptr == PTR_LAST) ? '0 : scan_ptr + 1'b1;
    end
  end

  // Saturating count of discarded out-of-range beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_inc && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router (NUM_CH=6, SEL_W=3): directed vectors with
// literal expectations, plus a queue/array-level model checked every cycle.
module tb_demux_stream_router;
  localparam int NCH = 6;
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic            bcast;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]  out_valid;
  logic [NCH-1:0]  out_ready;
  logic [2:0]      scan_ptr;
  logic [7:0]      drop_cnt;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  demux_stream_router #(.DATA_W(DW), .SEL_W(3), .NUM_CH(NCH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .bcast(bcast),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .scan_ptr(scan_ptr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] chd(input int c);
    return out_data[c*DW +: DW];
  endfunction

  // Behavioural model: channel occupancy/data arrays, pointer, drop count.
  bit           mv [NCH];
  logic [DW-1:0] md [NCH];
  int           mptr, mdrop;

  function automatic bit mbc();
`ifdef DEMUX_BCAST_EN
    return bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mready();
    int t;
    bit r;
    if (mbc()) begin
      r = 1;
      for (int i = 0; i < NCH; i++) r = r && (!mv[i] || out_ready[i]);
      return r;
    end
    t = mode ? mptr : int'(in_sel);
    if (t >= NCH) return 1;
    return !mv[t] || out_ready[t];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    int t;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin mv[i] = 0; md[i] = '0; end
      mptr = 0;
      mdrop = 0;
    end else begin
      acc = in_valid && mready();
      t = mode ? mptr : int'(in_sel);
      // Consumers take what they are ready for, then the new beat lands.
      for (int i = 0; i < NCH; i++) if (out_ready[i]) mv[i] = 0;
      if (acc) begin
        if (mbc()) begin
          for (int i = 0; i < NCH; i++) begin mv[i] = 1; md[i] = in_data; end
        end else if (t < NCH) begin
          mv[t] = 1;
          md[t] = in_data;
          if (mode) mptr = (mptr + 1) % NCH;
        end else if (mdrop < 255) begin
          mdrop = mdrop + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [NCH-1:0]    ev;
    logic [NCH*DW-1:0] ed;
    if (rst_n && run) begin
      for (int i = 0; i < NCH; i++) begin
        ev[i] = mv[i];
        ed[i*DW +: DW] = md[i];
      end
      chk("cyc_out_valid", 64'(out_valid), 64'(ev));
      chk("cyc_out_data", 64'(out_data), 64'(ed));
      chk("cyc_scan_ptr", 64'(scan_ptr), 64'(mptr));
      chk("cyc_drop_cnt", 64'(drop_cnt), 64'(mdrop));
      chk("cyc_in_ready", 64'(in_ready), 64'(mready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; mode = 0; in_data = '0; in_sel = '0; in_valid = 0;
    bcast = 0; out_ready = '1;
    repeat (2) step();
    rst_n = 1;
    run = 1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ptr", 64'(scan_ptr), 64'h0);

    // Addressed single beat to channel 5.
    in_sel = 3'd5; in_data = 8'hA5; in_valid = 1; #1;
    chk("a_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 0;
    chk("a_valid", 64'(out_valid), 64'h20);
    chk("a_data5", 64'(chd(5)), 64'hA5);
    step();
    chk("a_valid_after", 64'(out_valid), 64'h0);
    chk("a_data5_hold", 64'(chd(5)), 64'hA5);

    // Backpressure on channel 3 with coincident drain and load.
    out_ready = 6'b110111;
    in_sel = 3'd3; in_data = 8'h11; in_valid = 1; #1;
    chk("b_ready1", 64'(in_ready), 64'h1);
    step();
    in_data = 8'h22; #1;
    chk("b_ready_stall", 64'(in_ready), 64'h0);
    repeat (2) step();
    chk("b_hold_data", 64'(chd(3)), 64'h11);
    chk("b_hold_valid", 64'(out_valid), 64'h08);
    out_ready = '1; #1;
    chk("b_ready_release", 64'(in_ready), 64'h1);
    step();
    in_valid = 0;
    chk("b_valid3", 64'(out_valid), 64'h08);
    chk("b_data3", 64'(chd(3)), 64'h22);
    step();
    chk("b_drained", 64'(out_valid), 64'h0);

    // Scan mode: seven back-to-back beats wrap the pointer.
    mode = 1; in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      in_data = 8'(k);
      chk("c_ptr", 64'(scan_ptr), 64'(k % NCH));
      step();
      chk("c_valid", 64'(out_valid), 64'(1 << (k % NCH)));
      chk("c_data", 64'(chd(k % NCH)), 64'(k));
    end
    chk("c_ptr_end", 64'(scan_ptr), 64'h1);
    in_valid = 0;
    step();

    // Out-of-range addressed beats are swallowed; counter saturates.
    mode = 0; in_sel = 3'd7; in_data = 8'hEE; in_valid = 1;
    for (int n = 0; n < 300; n++) begin
      #1;
      chk("d_ready", 64'(in_ready), 64'h1);
      step();
      if (n == 9) chk("d_cnt10", 64'(drop_cnt), 64'd10);
      if (n == 254) chk("d_cnt255", 64'(drop_cnt), 64'd255);
    end
    chk("d_cnt_sat", 64'(drop_cnt), 64'd255);
    chk("d_no_valid", 64'(out_valid), 64'h0);

    // Back to scan: resumes from the held pointer.
    mode = 1; in_data = 8'h77;
    chk("e_ptr_held", 64'(scan_ptr), 64'h1);
    step();
    in_valid = 0;
    chk("e_valid", 64'(out_valid), 64'h02);
    chk("e_data1", 64'(chd(1)), 64'h77);
    chk("e_ptr_adv", 64'(scan_ptr), 64'h2);
    step();

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every channel, then fills all of them.
    mode = 0; out_ready = 6'b111011; in_sel = 3'd2; in_data = 8'h55; in_valid = 1;
    step();
    in_valid = 0;
    step();
    mode = 1; in_sel = 3'd5; bcast = 1; in_data = 8'h3C; in_valid = 1; #1;
    chk("f_bc_stall", 64'(in_ready), 64'h0);
    step();
    chk("f_bc_hold", 64'(out_valid), 64'h04);
    out_ready = 6'b000100; #1;
    chk("f_bc_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 0; bcast = 0;
    chk("f_bc_valid", 64'(out_valid), 64'h3F);
    for (int i = 0; i < NCH; i++) chk("f_bc_data", 64'(chd(i)), 64'h3C);
    chk("f_bc_ptr", 64'(scan_ptr), 64'h2);
    chk("f_bc_drop", 64'(drop_cnt), 64'd255);
    out_ready = '1;
    step();
`else
    // Without the broadcast feature bcast has no effect on routing.
    mode = 0; bcast = 1; in_sel = 3'd1; in_data = 8'h3C; in_valid = 1;
    step();
    in_valid = 0; bcast = 0;
    chk("f_nobc_valid", 64'(out_valid), 64'h02);
    chk("f_nobc_data", 64'(chd(1)), 64'h3C);
    step();
`endif

    // Fill every channel, then reset asynchronously mid-cycle.
    mode = 0; out_ready = '0; in_valid = 1;
    for (int s = 0; s < NCH; s++) begin
      in_sel = 3'(s); in_data = 8'(8'h40 + s);
      step();
    end
    in_valid = 0;
    chk("g_full", 64'(out_valid), 64'h3F);
    chk("g_data4", 64'(chd(4)), 64'h44);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("g_rst_valid", 64'(out_valid), 64'h0);
    chk("g_rst_data", 64'(out_data), 64'h0);
    chk("g_rst_ptr", 64'(scan_ptr), 64'h0);
    chk("g_rst_drop", 64'(drop_cnt), 64'h0);
    run = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Parametrised successor to the team's combinational 1-to-8 gated decoder.
- Routes a valid/ready input stream to one of NUM_CH output channels, each with its own one-entry output register and ready backpressure.
- Two routing modes: addressed (explicit select) and scan (auto round-robin pointer).
- Sits between a single producer and several consumer lanes in datapath fan-out.

Parameters:
DATA_W, 8, payload width in bits
SEL_W, 3, select/pointer width in bits
NUM_CH, 8, number of output channels; must satisfy 2 <= NUM_CH <= 2**SEL_W
CNT_W, 8, width of the dropped-beat counter

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
mode  input  1  0 = addressed (route by in_sel), 1 = scan (route by internal pointer)
in_data  input  DATA_W  input payload
in_sel  input  SEL_W  target channel in addressed mode
in_valid  input  1  producer has a beat
in_ready  output  1  router accepts the beat this cycle
bcast  input  1  broadcast request (used only when DEMUX_BCAST_EN is defined)
out_data  output  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W]
out_valid  output  NUM_CH  per-channel beat present
out_ready  input  NUM_CH  per-channel consumer ready
scan_ptr  output  SEL_W  current scan pointer
drop_cnt  output  CNT_W  count of out-of-range beats discarded

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, scan_ptr=0, drop_cnt=0. Asserting mid-transfer discards all held beats; no partial state survives.
- Target t = mode ? scan_ptr : in_sel; evaluated combinationally every cycle.
- in_ready = 1 if t >= NUM_CH, else (!out_valid[t] || out_ready[t]). in_ready must not depend on in_valid.
- accept = in_valid && in_ready.
- Per channel i, each clock:
  - accept and t==i: load in_data; out_valid[i]=1. Simultaneous drain and load keeps valid at 1 with the new data (full throughput).
  - else if out_ready[i]: out_valid[i]=0.
  - else: hold.
- out_data[i] holds its last value when out_valid[i]=0.
- Latency: accepted beat visible on out_valid/out_data the next cycle. Peak throughput is one beat per cycle.
- Out-of-range beat (addressed mode, in_sel >= NUM_CH): accepted and discarded; drop_cnt += 1, saturating at 2**CNT_W-1.
- Scan pointer:
  - Advances only on accept in scan mode; wraps NUM_CH-1 -> 0.
  - Holds when stalled, idle, or in addressed mode.
  - Mode may change on any cycle and takes effect that same cycle. Switching to scan resumes from the held pointer value.
- Stall: when the target channel is full and not draining, in_ready=0 and nothing else changes. Other channels continue to drain independently.

Optional Feature:
DEMUX_BCAST_EN
- Defined:
  - in_valid && bcast routes the beat to all NUM_CH channels.
  - in_ready = AND over all i of (!out_valid[i] || out_ready[i]).
  - On accept, every out_valid is set and every channel loads in_data.
  - scan_ptr and drop_cnt are unchanged. bcast overrides mode and in_sel.
- Undefined: bcast is ignored; the port remains present so the interface stays stable.

Test Plan:
- Reset with out_valid=0xFF set, rst_n low mid-cycle -> out_valid=0x00, scan_ptr=0, drop_cnt=0 immediately, with no clock needed.
- Addressed mode, NUM_CH=8, in_sel=5, in_data=0xA5, out_ready=0xFF -> next cycle out_valid=0x20 and channel 5 data = 0xA5; the cycle after, out_valid=0x00.
- Addressed mode, out_ready[3]=0, two beats to sel 3 (0x11, 0x22) -> first accepted; second sees in_ready=0 until out_ready[3]=1. In that cycle the drain and load coincide, out_valid[3] stays 1 and the data becomes 0x22.
- Scan mode, NUM_CH=6, SEL_W=3, 7 back-to-back beats 0..6 with all ready -> channels 0..5 receive 0..5, channel 0 receives 6; scan_ptr sequence 0,1,2,3,4,5,0,1.
- Addressed mode, NUM_CH=6, in_sel=7, 300 beats -> in_ready=1 throughout, no out_valid asserted, drop_cnt saturates at 255.
- With DEMUX_BCAST_EN, bcast=1, data 0x3C while out_valid[2]=1 and out_ready[2]=0 -> in_ready=0. After releasing out_ready[2], the beat loads all channels: out_valid=0xFF, each channel data = 0x3C.
